// File: rtl/mppt_pkg.sv
// Shared constants and types for the MPPT PWM generator.
package mppt_pkg;

  // Default field widths
  localparam int CNT_W_DEF  = 8;
  localparam int DEAD_W_DEF = 4;

  // Smallest legal period-minus-one value; a request of 0 is raised to this
  localparam int MIN_PERIOD = 1;

  // Top-level run state
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } run_state_e;

endpackage

// File: rtl/mppt_deadtime.sv
// Dead-time insertion: turns the raw PWM command into complementary
// high/low gate drives with a programmable blanking gap after every edge.
module mppt_deadtime
  import mppt_pkg::*;
#(
  parameter int DEAD_W = DEAD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stop,    // next cycle is not running: kill both gates now
  input  logic              run,     // current cycle is a running cycle
  input  logic              cmd,     // raw command, 1 = high side
  input  logic [DEAD_W-1:0] dead_i,
  output logic              hi,
  output logic              lo
);

  logic [DEAD_W-1:0] dcnt;
  logic              cmd_q;
  logic              act_q;   // previous cycle was a running cycle
  logic              evt;

  // A blanking event is the first running cycle or any change of the command
  assign evt = run && (!act_q || (cmd != cmd_q));

  // Gate drive registers; blank for dead_i cycles after each event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt  <= '0;
      cmd_q <= 1'b0;
      act_q <= 1'b0;
      hi    <= 1'b0;
      lo    <= 1'b0;
    end else if (stop || !run) begin
      dcnt  <= '0;
      cmd_q <= 1'b0;
      act_q <= 1'b0;
      hi    <= 1'b0;
      lo    <= 1'b0;
    end else begin
      act_q <= 1'b1;
      cmd_q <= cmd;
      if (evt && (dead_i != '0)) begin
        dcnt <= dead_i;
        hi   <= 1'b0;
        lo   <= 1'b0;
      end else if (!evt && (dcnt > DEAD_W'(1))) begin
        // Still inside the gap; the final count drives directly so the
        // gap lasts exactly dead_i cycles
        dcnt <= dcnt - DEAD_W'(1);
        hi   <= 1'b0;
        lo   <= 1'b0;
      end else begin
        dcnt <= '0;
        hi   <= cmd;
        lo   <= !cmd;
      end
    end
  end

endmodule

// File: rtl/mppt_pwm_gen.sv
// MPPT converter PWM generator: period counter, shadowed duty handshake,
// fault latch and dead-time insertion driving a half-bridge.
module mppt_pwm_gen
  import mppt_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DEAD_W = DEAD_W_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              en_i,
  input  logic [CNT_W-1:0]  duty_i,
  input  logic              duty_valid_i,
  output logic              duty_ready_o,
  input  logic [CNT_W-1:0]  period_i,
  input  logic [DEAD_W-1:0] dead_i,
  input  logic              fault_i,
  output logic              pwm_hi_o,
  output logic              pwm_lo_o,
  output logic              period_start_o,
  output logic              fault_o
);

  run_state_e       state, state_nx;
  logic             run, run_nx;
  logic [CNT_W-1:0] cnt, per_act, per_req;
  logic [CNT_W-1:0] duty_act, shadow;
  logic             pending;
  logic             wrap, ld_per, copy, take;
  logic [CNT_W:0]   per_p1, duty_eff;
  logic             cmd;

  // Run state register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Next state: fault_i wins over everything, fault clears only with en_i low
  always_comb begin
    state_nx = state;
    if (fault_i) begin
      state_nx = ST_FAULT;
    end else begin
      case (state)
        ST_IDLE:  state_nx = en_i ? ST_RUN : ST_IDLE;
        ST_RUN:   state_nx = en_i ? ST_RUN : ST_IDLE;
        ST_FAULT: state_nx = en_i ? ST_FAULT : ST_IDLE;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  assign run     = (state == ST_RUN);
  assign run_nx  = (state_nx == ST_RUN);
  assign per_req = (period_i < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : period_i;
  assign wrap    = run && (cnt == per_act);
  // Period reloads on the run start edge and on each wrap
  assign ld_per  = run_nx && (!run || wrap);

  // Period counter and active period
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt     <= '0;
      per_act <= CNT_W'(MIN_PERIOD);
    end else if (!run_nx) begin
      cnt <= '0;
    end else if (ld_per) begin
      cnt     <= '0;
      per_act <= per_req;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Shadowed duty: accept when empty, promote at wrap or while disabled
  assign copy = pending && (!en_i || wrap);
  assign take = duty_valid_i && !pending;

  // Duty shadow / active registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      duty_act <= '0;
      shadow   <= '0;
      pending  <= 1'b0;
    end else if (copy) begin
      duty_act <= shadow;
      pending  <= 1'b0;
    end else if (take) begin
      shadow  <= duty_i;
      pending <= 1'b1;
    end
  end

  // Limit duty to 100 % of the current period before comparing
  assign per_p1   = {1'b0, per_act} + (CNT_W+1)'(1);
  assign duty_eff = ({1'b0, duty_act} > per_p1) ? per_p1 : {1'b0, duty_act};
  assign cmd      = run && ({1'b0, cnt} < duty_eff);

  assign duty_ready_o   = !pending;
  assign period_start_o = run && (cnt == '0);
  assign fault_o        = (state == ST_FAULT);

  mppt_deadtime #(.DEAD_W(DEAD_W)) u_dead (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .stop   (!run_nx),
    .run    (run),
    .cmd    (cmd),
    .dead_i (dead_i),
    .hi     (pwm_hi_o),
    .lo     (pwm_lo_o)
  );

endmodule

// File: tb/tb_mppt_pwm_gen.sv
// Bench for mppt_pwm_gen: directed scenarios plus random stimulus, all
// checked cycle by cycle against a behavioural model of the converter PWM.
module tb_mppt_pwm_gen;
  localparam int CW = 8;
  localparam int DW = 4;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i = 1'b0;
  logic          en_i = 1'b0, duty_valid_i = 1'b0, fault_i = 1'b0;
  logic [CW-1:0] duty_i = '0, period_i = 8'd9;
  logic [DW-1:0] dead_i = '0;
  logic          duty_ready_o, pwm_hi_o, pwm_lo_o, period_start_o, fault_o;

  int checks = 0, errors = 0;
  int n_hi, n_lo, n_ps;

  // Model state: mode 0 idle, 1 running, 2 faulted
  int m_mode, m_cnt, m_per, m_duty, m_sh, m_pend, m_hi, m_lo;
  int m_first, m_cprev, m_evt, m_d, cyc = 0;

  mppt_pwm_gen #(.CNT_W(CW), .DEAD_W(DW)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .en_i(en_i),
    .duty_i(duty_i), .duty_valid_i(duty_valid_i), .duty_ready_o(duty_ready_o),
    .period_i(period_i), .dead_i(dead_i), .fault_i(fault_i),
    .pwm_hi_o(pwm_hi_o), .pwm_lo_o(pwm_lo_o),
    .period_start_o(period_start_o), .fault_o(fault_o)
  );

  initial forever #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_per = 1; m_duty = 0; m_sh = 0; m_pend = 0;
    m_hi = 0; m_lo = 0; m_first = 1; m_cprev = 0; m_evt = 0; m_d = 0;
  endtask

  // Advance the model across one rising edge using the applied inputs
  task automatic model_edge();
    int dl, pq;
    bit run, cmd, fault_n, run_n, wrap, evt;
    run     = (m_mode == 1);
    dl      = (m_duty > m_per + 1) ? m_per + 1 : m_duty;
    cmd     = run && (m_cnt < dl);
    fault_n = fault_i || (m_mode == 2 && en_i);
    run_n   = en_i && !fault_n;
    wrap    = run && (m_cnt == m_per);
    pq      = (period_i == 0) ? 1 : int'(period_i);
    // gate drives: silent unless this and the next cycle both run, then
    // blank for dead cycles after the run start or a command change
    if (!run_n || !run) begin
      m_hi = 0; m_lo = 0; m_first = 1;
    end else begin
      evt = m_first || (cmd != m_cprev);
      if (evt) begin m_evt = cyc; m_d = int'(dead_i); end
      if (cyc >= m_evt + m_d) begin m_hi = cmd; m_lo = !cmd; end
      else begin m_hi = 0; m_lo = 0; end
      m_cprev = cmd; m_first = 0;
    end
    if (m_pend && (!en_i || wrap)) begin m_duty = m_sh; m_pend = 0; end
    else if (duty_valid_i && !m_pend) begin m_sh = int'(duty_i); m_pend = 1; end
    if (!run_n) m_cnt = 0;
    else if (!run || wrap) begin m_cnt = 0; m_per = pq; end
    else m_cnt++;
    m_mode = run_n ? 1 : (fault_n ? 2 : 0);
    cyc++;
  endtask

  // One clock: check outputs mid-cycle, then step the model at the edge
  task automatic cycle();
    @(negedge wb_clk_i);
    chk("pwm_hi", 32'(pwm_hi_o), 32'(m_hi));
    chk("pwm_lo", 32'(pwm_lo_o), 32'(m_lo));
    chk("period_start", 32'(period_start_o), 32'(m_mode == 1 && m_cnt == 0));
    chk("fault_o", 32'(fault_o), 32'(m_mode == 2));
    chk("duty_ready", 32'(duty_ready_o), 32'(!m_pend));
    chk("overlap", 32'(pwm_hi_o & pwm_lo_o), 32'd0);
    n_hi += int'(pwm_hi_o); n_lo += int'(pwm_lo_o); n_ps += int'(period_start_o);
    @(posedge wb_clk_i);
    model_edge();
    #1;
  endtask

  task automatic run_n(input int n);
    repeat (n) cycle();
  endtask

  task automatic count(input string tag, input int n, input int eh, input int el, input int ep);
    n_hi = 0; n_lo = 0; n_ps = 0;
    run_n(n);
    chk({tag, "_hi_cycles"}, 32'(n_hi), 32'(eh));
    chk({tag, "_lo_cycles"}, 32'(n_lo), 32'(el));
    chk({tag, "_starts"}, 32'(n_ps), 32'(ep));
  endtask

  task automatic send_duty(input int v);
    bit done, was_ready;
    done = 0;
    duty_i = CW'(v); duty_valid_i = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      was_ready = (m_pend == 0);
      cycle();
      done = was_ready;
    end
    duty_valid_i = 1'b0;
    chk("handshake_in_time", 32'(done), 32'd1);
  endtask

  task automatic wait_cnt(input int c);
    bit found;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (m_mode == 1 && m_cnt == c) found = 1;
      else cycle();
    end
    chk("reach_count", 32'(found), 32'd1);
  endtask

  initial begin
    bit rst_done;
    model_reset();
    // reset state, asynchronous assertion before any edge
    #1 wb_rst_i = 1'b1;
    #1;
    chk("rst_hi", 32'(pwm_hi_o), 32'd0);
    chk("rst_lo", 32'(pwm_lo_o), 32'd0);
    chk("rst_ps", 32'(period_start_o), 32'd0);
    chk("rst_fault", 32'(fault_o), 32'd0);
    chk("rst_ready", 32'(duty_ready_o), 32'd1);
    @(posedge wb_clk_i); @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;

    // load duty 4 while idle, then run period 10 with no dead time
    send_duty(4);
    run_n(2);
    en_i = 1'b1; period_i = 8'd9; dead_i = 4'd0;
    run_n(15);
    count("d4_dead0", 10, 4, 6, 1);

    // dead time 2 shortens each pulse by 2
    dead_i = 4'd2;
    run_n(15);
    count("d4_dead2", 10, 2, 4, 1);

    // new duty mid-period waits for the wrap
    dead_i = 4'd0;
    run_n(15);
    wait_cnt(3);
    send_duty(7);
    chk("ready_low_mid", 32'(duty_ready_o), 32'd0);
    wait_cnt(0);
    count("d7_from_start", 10, 7, 3, 1);

    // duty extremes with dead time active: no gaps inside a period
    dead_i = 4'd2;
    send_duty(0);
    run_n(25);
    count("duty0", 10, 0, 10, 1);
    send_duty(200);
    run_n(25);
    count("duty200", 10, 10, 0, 1);

    // one-cycle fault pulse latches until disable
    fault_i = 1'b1;
    cycle();
    fault_i = 1'b0;
    count("fault", 10, 0, 0, 0);
    chk("fault_sticky", 32'(fault_o), 32'd1);
    en_i = 1'b0;
    send_duty(4);
    run_n(2);
    chk("fault_cleared", 32'(fault_o), 32'd0);
    en_i = 1'b1;
    run_n(3);
    run_n(15);
    count("restart", 10, 2, 4, 1);

    // random stimulus with one asynchronous reset mid-period
    rst_done = 0;
    for (int k = 0; k < 800; k++) begin
      en_i = ($urandom_range(0, 99) < 97);
      duty_valid_i = $urandom_range(0, 1) == 1;
      duty_i = CW'($urandom_range(0, 20));
      if ($urandom_range(0, 19) == 0) period_i = CW'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) dead_i = DW'($urandom_range(0, 4));
      fault_i = ($urandom_range(0, 249) == 0);
      if (!rst_done && k >= 400 && (m_hi != 0 || m_lo != 0)) begin
        rst_done = 1;
        #2 wb_rst_i = 1'b1;
        #1;
        chk("async_rst_hi", 32'(pwm_hi_o), 32'd0);
        chk("async_rst_lo", 32'(pwm_lo_o), 32'd0);
        model_reset();
        @(negedge wb_clk_i);
        chk("rst_hold_ready", 32'(duty_ready_o), 32'd1);
        chk("rst_hold_ps", 32'(period_start_o), 32'd0);
        chk("rst_hold_fault", 32'(fault_o), 32'd0);
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
      end
      cycle();
    end
    chk("async_reset_exercised", 32'(rst_done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mppt_pwm_gen.md
MPPT_PWM_GEN -- requirements
Module: mppt_pwm_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning the width of the period, duty and counter fields.
REQ-002 SHALL have parameter DEAD_W, default 4, meaning the width of the dead-time field.
REQ-003 SHALL have port wb_clk_i  input  1  meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port wb_rst_i  input  1  meaning the reset; it is asynchronous and active-high.
REQ-005 SHALL have port en_i  input  1  meaning run enable; low idles the block and clears any fault.
REQ-006 SHALL have port duty_i  input  CNT_W  meaning the duty request from the MPPT core.
REQ-007 SHALL have port duty_valid_i  input  1  meaning duty_i is valid.
REQ-008 SHALL have port duty_ready_o  output  1  meaning the shadow register can accept a duty value.
REQ-009 SHALL have port period_i  input  CNT_W  meaning the PWM period minus one, in clocks.
REQ-010 SHALL have port dead_i  input  DEAD_W  meaning the dead-time, in clocks.
REQ-011 SHALL have port fault_i  input  1  meaning the overcurrent/overvoltage shutdown request.
REQ-012 SHALL have port pwm_hi_o  output  1  meaning the high-side gate drive.
REQ-013 SHALL have port pwm_lo_o  output  1  meaning the low-side gate drive.
REQ-014 SHALL have port period_start_o  output  1  meaning a one-cycle pulse at the start of each period, used as the ADC sample trigger.
REQ-015 SHALL have port fault_o  output  1  meaning the latched fault flag.

Function
REQ-016 Counter SHALL count 0..per_act and wrap to 0, holding 0 while en_i=0 or fault_o=1.
REQ-017 per_act SHALL be loaded from period_i (0 clamped to 1) when en_i rises and at every wrap (cnt==per_act).
REQ-018 Duty handshake SHALL complete on duty_valid_i&&duty_ready_o: duty_i enters the shadow register, pending=1, and duty_ready_o=0.
REQ-019 At wrap, or while en_i=0, a pending shadow value SHALL copy to duty_act, and duty_ready_o SHALL return to 1 in the next cycle.
REQ-020 duty_act SHALL be clamped to per_act+1 so that duty never exceeds 100%.
REQ-021 Command SHALL be cmd = (cnt < duty_act): duty 0 gives low side only, and per_act+1 gives high side only.
REQ-022 On any change of cmd, and on en_i rise, the dead counter SHALL load dead_i and both outputs SHALL be driven low while it is nonzero.
REQ-023 With the dead counter at zero: pwm_hi_o=cmd and pwm_lo_o=!cmd, both registered, so outputs lag cmd by exactly 1 clock when dead_i=0.
REQ-024 pwm_hi_o and pwm_lo_o SHALL never be 1 in the same cycle under any input sequence.
REQ-025 period_start_o SHALL be 1 for exactly the cycle in which cnt==0 while running.
REQ-026 fault_i=1 SHALL set fault_o on the next edge and force both outputs to 0 on that same edge.
REQ-027 fault_o SHALL be sticky until en_i=0, and fault_i SHALL take priority over all other inputs.
REQ-028 If dead_i >= a pulse width, that output SHALL simply stay low for the pulse; no glitch or overlap is permitted.

Reset
REQ-029 During wb_rst_i SHALL hold: cnt=0, per_act=1, duty_act=0, shadow=0, pending=0, and dead counter=0.
REQ-030 During wb_rst_i outputs SHALL hold pwm_hi_o=0, pwm_lo_o=0, period_start_o=0, fault_o=0, and duty_ready_o=1.
REQ-031 Reset asserted mid-period SHALL force both gate outputs low asynchronously, without waiting for a clock edge.

Structure
REQ-032 Shared package mppt_pkg SHALL hold the CNT_W/DEAD_W defaults and the minimum-period constant.
REQ-033 The dead-time insertion SHALL be a sub-module mppt_deadtime (inputs cmd and dead_i; outputs hi/lo), instantiated once.

Verification
REQ-034 Test: period_i=9, duty 4, dead_i=0, en_i=1 -> hi for 4 and lo for 6 clocks per 10-clock period, with period_start_o every 10 clocks.
REQ-035 Test: period_i=9, duty 4, dead_i=2 -> hi high 2 clocks and lo high 4 clocks per period, with both low for 2 clocks at each edge.
REQ-036 Test: new duty 7 accepted mid-period -> duty_ready_o=0 until wrap, and duty 7 applies from the next period_start_o.
REQ-037 Test: duty 0 and duty 200 with period_i=9 -> constant lo, then constant hi after the clamp, with no dead gaps inside a period.
REQ-038 Test: fault_i pulse for 1 clock -> both outputs 0 and fault_o=1 until en_i is low, then a clean restart with dead-time.
REQ-039 Test: random duty/period/dead stimulus with an asynchronous wb_rst_i mid-period -> zero hi/lo overlap, and outputs 0 immediately on reset.
